vga_scan_gen: RTL and testbench
===============================

# vga_scan_gen

VGA 640x480@60 scan generator that drives the pixel-coordinate side of every flag module. It produces `pix_x`/`pix_y` for a combinational flag renderer, accepts the returned 6-bit `color`, and emits registered, blanked RGB222 together with hsync and vsync aligned to it. It also provides a frame-start pulse and a frame counter for animated flags.

## Interface
- `H_DISPLAY`, default 640: visible columns.
- `H_FRONT`, default 16: horizontal front porch.
- `H_SYNC`, default 96: hsync width.
- `H_BACK`, default 48: horizontal back porch.
- `V_DISPLAY`, default 480: visible lines.
- `V_FRONT`, default 10: vertical front porch.
- `V_SYNC`, default 2: vsync width.
- `V_BACK`, default 33: vertical back porch.
- `SYNC_NEG`, default 1: 1 means sync pulses are active-low.
- `clk`  in  1: pixel clock (25.175 MHz nominal). One clock only.
- `reset`  in  1: synchronous, active-high reset.
- `pix_x`  out  10: current column counter, 0..H_TOTAL-1.
- `pix_y`  out  10: current line counter, 0..V_TOTAL-1.
- `display_on`  out  1: high when pix_x < H_DISPLAY and pix_y < V_DISPLAY.
- `color`  in  6: {R[1:0],G[1:0],B[1:0]} returned by the flag for the current pix_x/pix_y, same cycle.
- `rgb`  out  6: registered, blanked colour.
- `hsync`  out  1: registered horizontal sync.
- `vsync`  out  1: registered vertical sync.
- `frame_start`  out  1: one-cycle pulse, registered.
- `frame_count`  out  8: number of completed frames.

## Operation
- H_TOTAL is the sum of the four H parameters (800). V_TOTAL is the sum of the four V parameters (525). Both totals must be ≤ 1024; elaboration fails otherwise.
- Horizontal counter:
  - Increments every cycle.
  - At H_TOTAL-1 it wraps to 0 and asserts `h_wrap` for that cycle.
- Vertical counter:
  - Increments only on `h_wrap`.
  - At V_TOTAL-1 together with `h_wrap`, it wraps to 0 and asserts `v_wrap`.
- `display_on`, the raw hsync and the raw vsync are combinational decodes of the counters.
  - Raw hsync is active for pix_x in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] = [656,751].
  - Raw vsync is active for pix_y in [490,491]. vsync spans whole lines, from pix_x 0 to 799.
- Output stage, registered every cycle:
  - `rgb` <= display_on ? color : 0.
  - `hsync` <= raw_hsync XOR SYNC_NEG.
  - `vsync` <= raw_vsync XOR SYNC_NEG.
  - `frame_start` <= (pix_x==0 && pix_y==0).
- `frame_count` increments on `v_wrap` and wraps 255 -> 0.
- Reset values:
  - pix_x=0, pix_y=0, so display_on=1.
  - rgb=0, hsync=vsync=SYNC_NEG (inactive), frame_start=0, frame_count=0.
- Reset asserted mid-line or mid-frame: the next edge forces the reset values, with no partial-frame increment of frame_count. The first frame_start follows one cycle after reset is released.
- `color` is sampled only when display_on=1. Outside the visible area rgb is forced to 0, whatever the flag returns.

## Timing
- Counter latency is zero: pix_x/pix_y change on the clk edge, and `color` must settle within the same cycle.
- Output latency is 1 cycle. rgb, hsync, vsync and frame_start for coordinate (x,y) all appear the cycle after pix_x=x, pix_y=y, so they are mutually aligned.
- Per-line event order:
  - Visible pixels at counter 0..639.
  - Blank at 640..655.
  - Sync at 656..751.
  - Back porch at 752..799.
- The line period is exactly 800 cycles and the frame period is exactly 420000 cycles.
- frame_start is high for exactly one cycle per frame.
- frame_count changes on the edge at which pix_y goes 524 -> 0. It is therefore already incremented when frame_start is seen.
- When h_wrap and v_wrap coincide (799,524), both counters clear on the same edge.

## Structure
- Shared header `vga_timing.vh` holds:
  - the 640x480 default timing constants;
  - the colour width (6);
  - the `BLACK` encoding used for blanking.

  The flag modules also include this header.
- One sub-module, `vga_axis_counter`:
  - parameters DISPLAY/FRONT/SYNC/BACK;
  - inputs clk, reset, enable;
  - outputs count[9:0], in_display, in_sync, wrap.
- `vga_axis_counter` is instantiated twice:
  - horizontal instance with enable=1;
  - vertical instance with enable=h_wrap.
- The top level holds only the output register stage and frame_count.

## Test plan
- **Reset:** assert reset for 3 cycles at pix_x=300, pix_y=100 -> pix_x=0, pix_y=0, rgb=0, hsync=vsync=1, frame_count=0. The first frame_start comes 1 cycle after release.
- **Line timing:** run 2 lines -> hsync low for exactly 96 cycles, the first low cycle at 657 cycles after pix_x=0. Consecutive falling edges are 800 cycles apart.
- **Frame timing:** run 1 full frame -> vsync low for exactly 1600 cycles, starting when pix_y=490 is registered. frame_start is repeated every 420000 cycles. frame_count goes 0 -> 1.
- **Blanking:** drive color=6'h3F constantly -> rgb=6'h3F for registered x<640, y<480. rgb=0 at x=640..799 and on lines 480..524.
- **Alignment:** drive color = pix_x[5:0] -> rgb on cycle n+1 equals pix_x[5:0] from cycle n, for every visible pixel.
- **Wrap:** force 256 frames (or preload via reset-free run in a shortened-parameter build, H=8/2/2/2, V=4/1/1/1) -> frame_count 255 -> 0 without glitch. Counters wrap at (13,6) -> (0,0).

Source files
------------

// File: rtl/vga_scan_gen_pkg.sv
// Shared VGA timing constants, colour width and blanking encoding for the scan
// generator and the flag renderers that consume its pixel coordinates.
package vga_scan_gen_pkg;

   localparam int H_DISPLAY_DEF = 640;
   localparam int H_FRONT_DEF   = 16;
   localparam int H_SYNC_DEF    = 96;
   localparam int H_BACK_DEF    = 48;
   localparam int V_DISPLAY_DEF = 480;
   localparam int V_FRONT_DEF   = 10;
   localparam int V_SYNC_DEF    = 2;
   localparam int V_BACK_DEF    = 33;

   localparam int CNT_W     = 10;
   localparam int MAX_TOTAL = 1024;
   localparam int COLOR_W   = 6;

   localparam logic [COLOR_W-1:0] BLACK = 6'h00;

endpackage

// File: rtl/vga_axis_counter.sv
// One scan axis: a wrapping position counter with display and sync window
// decodes. The horizontal axis runs freely; the vertical axis steps on line wrap.
module vga_axis_counter
   import vga_scan_gen_pkg::*;
#(
   parameter int DISPLAY = H_DISPLAY_DEF,
   parameter int FRONT   = H_FRONT_DEF,
   parameter int SYNC    = H_SYNC_DEF,
   parameter int BACK    = H_BACK_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   output logic [CNT_W-1:0] count,
   output logic             in_display,
   output logic             in_sync,
   output logic             wrap
);

   localparam int TOTAL      = DISPLAY + FRONT + SYNC + BACK;
   localparam int SYNC_START = DISPLAY + FRONT;
   localparam int SYNC_END   = DISPLAY + FRONT + SYNC - 1;

   localparam logic [CNT_W-1:0] LAST_C       = CNT_W'(TOTAL - 1);
   localparam logic [CNT_W-1:0] DISPLAY_C    = CNT_W'(DISPLAY);
   localparam logic [CNT_W-1:0] SYNC_START_C = CNT_W'(SYNC_START);
   localparam logic [CNT_W-1:0] SYNC_END_C   = CNT_W'(SYNC_END);

   generate
      if (TOTAL > MAX_TOTAL) begin : g_total_too_large
         $error("vga_axis_counter: axis total exceeds counter range");
      end
   endgenerate

   logic [CNT_W-1:0] count_r;

   // Position counter: advances when enabled, clears after the last position.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_r <= {CNT_W{1'b0}};
      end else if (enable) begin
         if (count_r == LAST_C) begin
            count_r <= {CNT_W{1'b0}};
         end else begin
            count_r <= count_r + 10'd1;
         end
      end else begin
         count_r <= count_r;
      end
   end

   assign count      = count_r;
   assign in_display = (count_r < DISPLAY_C);
   assign in_sync    = (count_r >= SYNC_START_C) && (count_r <= SYNC_END_C);
   assign wrap       = enable && (count_r == LAST_C);

endmodule

// File: rtl/vga_scan_gen.sv
// VGA scan generator: pixel coordinates for a flag renderer, and registered,
// blanked RGB222 with hsync/vsync/frame_start aligned one cycle behind them.
module vga_scan_gen
   import vga_scan_gen_pkg::*;
#(
   parameter int H_DISPLAY = H_DISPLAY_DEF,
   parameter int H_FRONT   = H_FRONT_DEF,
   parameter int H_SYNC    = H_SYNC_DEF,
   parameter int H_BACK    = H_BACK_DEF,
   parameter int V_DISPLAY = V_DISPLAY_DEF,
   parameter int V_FRONT   = V_FRONT_DEF,
   parameter int V_SYNC    = V_SYNC_DEF,
   parameter int V_BACK    = V_BACK_DEF,
   parameter int SYNC_NEG  = 1
) (
   input  logic               clk,
   input  logic               reset,
   output logic [CNT_W-1:0]   pix_x,
   output logic [CNT_W-1:0]   pix_y,
   output logic               display_on,
   input  logic [COLOR_W-1:0] color,
   output logic [COLOR_W-1:0] rgb,
   output logic               hsync,
   output logic               vsync,
   output logic               frame_start,
   output logic [7:0]         frame_count
);

   localparam logic SYNC_POL = (SYNC_NEG != 0) ? 1'b1 : 1'b0;

   logic h_wrap_s, v_wrap_s;
   logic h_disp_s, v_disp_s;
   logic h_sync_s, v_sync_s;

   vga_axis_counter #(
      .DISPLAY (H_DISPLAY),
      .FRONT   (H_FRONT),
      .SYNC    (H_SYNC),
      .BACK    (H_BACK)
   ) u_h_counter (
      .clk        (clk),
      .reset      (reset),
      .enable     (1'b1),
      .count      (pix_x),
      .in_display (h_disp_s),
      .in_sync    (h_sync_s),
      .wrap       (h_wrap_s)
   );

   // The vertical wrap already implies a horizontal wrap through its enable.
   vga_axis_counter #(
      .DISPLAY (V_DISPLAY),
      .FRONT   (V_FRONT),
      .SYNC    (V_SYNC),
      .BACK    (V_BACK)
   ) u_v_counter (
      .clk        (clk),
      .reset      (reset),
      .enable     (h_wrap_s),
      .count      (pix_y),
      .in_display (v_disp_s),
      .in_sync    (v_sync_s),
      .wrap       (v_wrap_s)
   );

   assign display_on = h_disp_s & v_disp_s;

   logic [COLOR_W-1:0] rgb_r;
   logic               hsync_r;
   logic               vsync_r;
   logic               frame_start_r;
   logic [7:0]         frame_count_r;

   // Output stage: everything for coordinate (x,y) lands on the following edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         rgb_r         <= BLACK;
         hsync_r       <= SYNC_POL;
         vsync_r       <= SYNC_POL;
         frame_start_r <= 1'b0;
         frame_count_r <= 8'd0;
      end else begin
         rgb_r         <= display_on ? color : BLACK;
         hsync_r       <= h_sync_s ^ SYNC_POL;
         vsync_r       <= v_sync_s ^ SYNC_POL;
         frame_start_r <= (pix_x == 10'd0) && (pix_y == 10'd0);
         if (v_wrap_s) begin
            frame_count_r <= frame_count_r + 8'd1;
         end else begin
            frame_count_r <= frame_count_r;
         end
      end
   end

   assign rgb         = rgb_r;
   assign hsync       = hsync_r;
   assign vsync       = vsync_r;
   assign frame_start = frame_start_r;
   assign frame_count = frame_count_r;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Scoreboard bench for vga_scan_gen in a shortened 14x7 timing build; the
// reference derives every output from the number of cycles since reset.
module tb_vga_scan_gen;

   localparam int HD = 8, HF = 2, HS = 2, HB = 2;
   localparam int VD = 4, VF = 1, VS = 1, VB = 1;
   localparam int HT = HD + HF + HS + HB;
   localparam int VT = VD + VF + VS + VB;
   localparam int FT = HT * VT;
   localparam int P1_CYC    = 3000;
   localparam int TOTAL_CYC = 28400;

   logic       clk = 1'b0;
   logic       reset;
   logic [9:0] pix_x, pix_y;
   logic       display_on;
   logic [5:0] color;
   logic [5:0] rgb;
   logic       hsync, vsync, frame_start;
   logic [7:0] frame_count;

   vga_scan_gen #(
      .H_DISPLAY (HD), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
      .V_DISPLAY (VD), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
      .SYNC_NEG  (1)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .pix_x       (pix_x),
      .pix_y       (pix_y),
      .display_on  (display_on),
      .color       (color),
      .rgb         (rgb),
      .hsync       (hsync),
      .vsync       (vsync),
      .frame_start (frame_start),
      .frame_count (frame_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int x, y, disp, rgb, hs, vs, fs, fc;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference: position t cycles after reset in a raster of HT x VT.
   function automatic int mx(int t);   return t % HT;                endfunction
   function automatic int my(int t);   return (t / HT) % VT;         endfunction
   function automatic int mfc(int t);  return (t / FT) % 256;        endfunction
   function automatic int mdisp(int t); return (mx(t) < HD && my(t) < VD) ? 1 : 0; endfunction
   function automatic int mhs(int t);
      return (mx(t) >= HD + HF && mx(t) < HD + HF + HS) ? 1 : 0;
   endfunction
   function automatic int mvs(int t);
      return (my(t) >= VD + VF && my(t) < VD + VF + VS) ? 1 : 0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   function automatic exp_t counters_at(int t);
      exp_t e;
      e.x = mx(t); e.y = my(t); e.disp = mdisp(t); e.fc = mfc(t);
      e.rgb = 0; e.hs = 1; e.vs = 1; e.fs = 0;
      return e;
   endfunction

   // Driver: random reset bursts and colour modes; pushes the post-edge expectation.
   initial begin
      int   t;
      int   hold;
      int   mode;
      exp_t e;
      reset = 1'b1;
      color = 6'h00;
      t     = 0;
      hold  = 2;
      mode  = 0;
      q.push_back(counters_at(0));
      for (int c = 0; c < TOTAL_CYC; c++) begin
         @(negedge clk);
         if (c == P1_CYC) hold = 3;
         if (hold == 0 && c < P1_CYC && $urandom_range(0, 299) == 0) hold = 3;
         if (c % 400 == 0) mode = $urandom_range(0, 2);
         case (mode)
            0:       color = 6'($urandom_range(0, 63));
            1:       color = 6'h3F;
            default: color = pix_x[5:0];
         endcase
         if (hold > 0) begin
            reset = 1'b1;
            hold--;
            t = 0;
            e = counters_at(0);
         end else begin
            reset = 1'b0;
            e = counters_at(t + 1);
            e.rgb = (mdisp(t) != 0) ? int'(color) : 0;
            e.hs  = (mhs(t) != 0) ? 0 : 1;
            e.vs  = (mvs(t) != 0) ? 0 : 1;
            e.fs  = (mx(t) == 0 && my(t) == 0) ? 1 : 0;
            t++;
         end
         q.push_back(e);
      end
      @(posedge clk);
      #2;
      chk("queue_drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Monitor: after every edge, compare the DUT against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("pix_x",       pix_x,       e.x);
            chk("pix_y",       pix_y,       e.y);
            chk("display_on",  display_on,  e.disp);
            chk("rgb",         rgb,         e.rgb);
            chk("hsync",       hsync,       e.hs);
            chk("vsync",       vsync,       e.vs);
            chk("frame_start", frame_start, e.fs);
            chk("frame_count", frame_count, e.fc);
         end
      end
   end

endmodule
